// File: rtl/board_draw_scheduler.sv
// Board redraw sequencer: snapshots the 3x3 grid and sweeps every pixel of the
// nine cells into the VGA adapter, one plot strobe per pixel, yielding to hold.
module board_draw_scheduler #(
  parameter int unsigned PIECE_W = 27,
  parameter bit          AUTO    = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [17:0] grid,
  input  logic        start,
  input  logic        hold,
  input  logic [7:0]  x_base,
  input  logic [6:0]  y_base,
  output logic [3:0]  cell_sel,
  output logic [17:0] grid_snap,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_DONE
  } state_t;

  localparam logic [4:0] OFF_LAST  = 5'(PIECE_W - 1);
  localparam logic [3:0] CELL_LAST = 4'd8;

  state_t      state, state_nx;
  logic [4:0]  off_x, off_y;
  logic [3:0]  cell_q;
  logic [17:0] snap_q;
  logic        pending;
  logic        req;
  logic        advance;
  logic        last_x, last_y, last_pix;

  assign req      = start | (AUTO & (grid != snap_q));
  assign advance  = (state == S_DRAW) & ~hold;
  assign last_x   = (off_x == OFF_LAST);
  assign last_y   = (off_y == OFF_LAST);
  assign last_pix = last_x & last_y & (cell_q == CELL_LAST);

  always_comb begin
    state_nx = state;
    plot     = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (pending) state_nx = S_LOAD;
      end
      S_LOAD: state_nx = S_DRAW;
      S_DRAW: begin
        plot = ~hold;
        if (advance && last_pix) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = (pending || req) ? S_LOAD : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      off_x   <= '0;
      off_y   <= '0;
      cell_q  <= '0;
      snap_q  <= '0;
      pending <= 1'b1;
    end else begin
      state <= state_nx;
      // The grid is compared against the value being captured in LOAD, so only
      // an explicit start can re-arm a request in that cycle.
      if (state == S_LOAD)
        pending <= start;
      else if (req)
        pending <= 1'b1;

      if (state == S_LOAD) begin
        snap_q <= grid;
        off_x  <= '0;
        off_y  <= '0;
        cell_q <= '0;
      end else if (advance && !last_pix) begin
        if (last_x) begin
          off_x <= '0;
          if (last_y) begin
            off_y  <= '0;
            cell_q <= cell_q + 4'd1;
          end else begin
            off_y <= off_y + 5'd1;
          end
        end else begin
          off_x <= off_x + 5'd1;
        end
      end
    end
  end

  assign cell_sel  = cell_q;
  assign grid_snap = snap_q;
  assign x_out     = x_base + {3'b000, off_x};
  assign y_out     = y_base + {2'b00, off_y};

endmodule

// File: tb/tb_board_draw_scheduler.sv
// Self-checking bench for board_draw_scheduler: a table of reset/start vectors,
// hand-written corner sequences and a randomized run against a pixel-index model.
module tb_board_draw_scheduler;

  localparam int PW       = 27;
  localparam int CELL_PIX = PW * PW;
  localparam int TOTAL    = 9 * CELL_PIX;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAW = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        resetn, start, hold;
  logic [17:0] grid;
  logic [7:0]  x_base;
  logic [6:0]  y_base;
  logic [3:0]  cell_sel;
  logic [17:0] grid_snap;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic        plot, busy, done;

  always #5 clk = ~clk;

  board_draw_scheduler #(.PIECE_W(PW), .AUTO(1'b1)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .grid     (grid),
    .start    (start),
    .hold     (hold),
    .x_base   (x_base),
    .y_base   (y_base),
    .cell_sel (cell_sel),
    .grid_snap(grid_snap),
    .x_out    (x_out),
    .y_out    (y_out),
    .plot     (plot),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a sweep is a pixel index 0..TOTAL-1 from which cell and
  // offsets are derived arithmetically.
  int          m_mode = M_IDLE;
  int          m_p    = 0;
  logic [17:0] m_snap = '0;
  bit          m_pend = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    bit req;
    req = start || (grid != m_snap);
    if (!resetn) begin
      m_mode = M_IDLE; m_p = 0; m_snap = '0; m_pend = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (m_pend) m_mode = M_LOAD;
          if (req) m_pend = 1'b1;
        end
        M_LOAD: begin
          m_snap = grid; m_p = 0; m_mode = M_DRAW; m_pend = start;
        end
        M_DRAW: begin
          if (!hold) begin
            if (m_p == TOTAL - 1) m_mode = M_DONE;
            else m_p++;
          end
          if (req) m_pend = 1'b1;
        end
        default: begin
          m_mode = (m_pend || req) ? M_LOAD : M_IDLE;
          if (req) m_pend = 1'b1;
        end
      endcase
    end
  endtask

  task automatic model_check();
    bit exp_plot;
    exp_plot = (m_mode == M_DRAW) && !hold;
    chk("busy", int'(busy), int'(m_mode != M_IDLE));
    chk("done", int'(done), int'(m_mode == M_DONE));
    chk("plot", int'(plot), int'(exp_plot));
    chk("cell_sel", int'(cell_sel), m_p / CELL_PIX);
    chk("grid_snap", int'(grid_snap), int'(m_snap));
    if (exp_plot) begin
      chk("x_out", int'(x_out), (int'(x_base) + m_p % PW) % 256);
      chk("y_out", int'(y_out), (int'(y_base) + (m_p % CELL_PIX) / PW) % 128);
    end
  endtask

  task automatic edge_only();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic tick();
    edge_only();
    model_check();
  endtask

  task automatic wait_first_plot(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (plot) begin ok = 1'b1; break; end
    end
    if (!ok) chk("first_plot_timeout", 0, 1);
  endtask

  task automatic wait_done(input int budget, output int plots);
    bit ok;
    ok = 1'b0;
    plots = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (plot) plots++;
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  typedef struct {
    bit         rn, st, hd;
    logic [7:0] xb;
    logic [6:0] yb;
    bit         e_busy, e_plot, e_done;
    int         e_cell, e_x, e_y;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int plots, n, first, t_done;
    bit changed;

    //          rn st hd  xb   yb  busy plot done cell  x    y
    vecs[0] = '{0, 0, 0, 250, 120, 0,   0,   0,   0,   0,   0};
    vecs[1] = '{1, 0, 0, 250, 120, 1,   0,   0,   0,   0,   0};
    vecs[2] = '{1, 0, 0, 250, 120, 1,   1,   0,   0,   250, 120};
    vecs[3] = '{1, 0, 1, 250, 120, 1,   0,   0,   0,   0,   0};
    vecs[4] = '{1, 0, 0, 250, 120, 1,   1,   0,   0,   251, 120};
    vecs[5] = '{1, 0, 0, 254, 120, 1,   1,   0,   0,   0,   120};
    vecs[6] = '{1, 0, 0, 254, 127, 1,   1,   0,   0,   1,   127};
    vecs[7] = '{1, 1, 0, 0,   0,   1,   1,   0,   0,   4,   0};

    resetn = 1'b0; start = 1'b0; hold = 1'b0; grid = '0; x_base = '0; y_base = '0;
    #2;
    foreach (vecs[i]) begin
      resetn = vecs[i].rn; start = vecs[i].st; hold = vecs[i].hd;
      x_base = vecs[i].xb; y_base = vecs[i].yb;
      edge_only();
      chk("vec_busy", int'(busy), int'(vecs[i].e_busy));
      chk("vec_plot", int'(plot), int'(vecs[i].e_plot));
      chk("vec_done", int'(done), int'(vecs[i].e_done));
      chk("vec_cell", int'(cell_sel), vecs[i].e_cell);
      if (vecs[i].e_plot) begin
        chk("vec_x", int'(x_out), vecs[i].e_x);
        chk("vec_y", int'(y_out), vecs[i].e_y);
      end
    end
    start = 1'b0;

    // Post-reset sweep with grid=0: exactly one full sweep, then done.
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
    x_base = 8'd40; y_base = 7'd30;
    wait_done(8000, plots);
    chk("reset_sweep_plots", plots, TOTAL);
    chk("last_cell", int'(cell_sel), 8);
    tick(); chk("idle_after_sweep", int'(busy), 0);
    tick(); tick();

    // Grid change from idle triggers an automatic sweep of the new grid.
    grid = 18'h00001;
    tick(); chk("auto_pending_busy", int'(busy), 0);
    tick(); chk("auto_load_busy", int'(busy), 1);
    wait_first_plot(10);
    chk("auto_first_cell", int'(cell_sel), 0);
    chk("auto_first_snap", int'(grid_snap), 18'h00001);
    wait_done(8000, plots);
    chk("auto_sweep_plots", plots, TOTAL - 1);
    tick(); tick();

    // Grid toggled mid-sweep: old snapshot kept, then an immediate re-sweep.
    start = 1'b1; tick(); start = 1'b0;
    wait_first_plot(10);
    n = 1; changed = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (n == 100 && !changed) begin grid = 18'h2AAAA; changed = 1'b1; end
      tick();
      if (plot) n++;
      if (done) break;
    end
    chk("toggle_sweep_plots", n, TOTAL);
    chk("toggle_done", int'(done), 1);
    chk("toggle_old_snap", int'(grid_snap), 18'h00001);
    tick(); chk("toggle_reload_busy", int'(busy), 1);
    tick(); chk("toggle_new_snap", int'(grid_snap), 18'h2AAAA);
    chk("toggle_new_plot", int'(plot), 1);
    wait_done(8000, plots);
    chk("toggle_second_plots", plots, TOTAL - 1);
    tick(); tick();

    // Hold for 5 cycles at cell 4, off_x=10, off_y=3.
    x_base = 8'd20; y_base = 7'd10;
    start = 1'b1; tick(); start = 1'b0;
    first = -1;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (plot && first < 0) first = cyc;
      if (m_mode == M_DRAW && m_p == 4 * CELL_PIX + 3 * PW + 10) break;
    end
    chk("hold_pos_x", int'(x_out), 30);
    chk("hold_pos_y", int'(y_out), 13);
    hold = 1'b1; #1;
    chk("hold_plot_low", int'(plot), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_plot_low", int'(plot), 0);
    end
    tick();
    hold = 1'b0; #1;
    chk("hold_resume_plot", int'(plot), 1);
    chk("hold_resume_x", int'(x_out), 30);
    chk("hold_resume_y", int'(y_out), 13);
    chk("hold_resume_cell", int'(cell_sel), 4);
    wait_done(8000, plots);
    t_done = cyc;
    chk("hold_sweep_cycles", t_done - first, TOTAL + 5);
    tick(); tick();

    // Reset mid-sweep at cell 3, then a fresh full sweep.
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (m_mode == M_DRAW && m_p == 3 * CELL_PIX + 50) break;
    end
    chk("abort_cell", int'(cell_sel), 3);
    resetn = 1'b0;
    tick();
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    resetn = 1'b1;
    wait_done(8000, plots);
    chk("abort_fresh_plots", plots, TOTAL);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      start  = ($urandom % 300) == 0;
      hold   = ($urandom % 8) == 0;
      x_base = 8'($urandom);
      y_base = 7'($urandom);
      if (($urandom % 2500) == 0) grid = 18'($urandom);
      resetn = ($urandom % 6000) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
